// File: rtl/rgb2ycc.sv
// BT.601 full-range RGB -> YCbCr converter. It has a 3-stage pipeline, a frame-latched mode,
// sync delay matching, and line-length measurement.
module rgb2ycc #(
    parameter  int COLORDEPTH = 8,
    parameter  int MAXW       = 2048,
    localparam int CNTW       = $clog2(MAXW + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*COLORDEPTH-1:0] rgb_i,
    input  logic                    dv_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    input  logic [1:0]              mode_i,
    output logic [3*COLORDEPTH-1:0] ycc_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic                    line_end_o,
    output logic [CNTW-1:0]         line_len_o,
    output logic [1:0]              mode_o
);
    localparam int CD   = COLORDEPTH;
    localparam int W    = CD + 10;
    localparam int MAXV = (1 << CD) - 1;
    localparam logic [CD-1:0]       HALF = CD'(1 << (CD - 1));
    localparam logic signed [W-1:0] RND  = W'(128);
    localparam logic signed [W-1:0] OFF  = W'(1 << (CD - 1));
    localparam logic signed [W-1:0] VMAX = W'(MAXV);
    localparam int COEF [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};

    logic [1:0]      mode_q, mode_eff;
    logic            vs_prev_q;
    logic [CNTW-1:0] cnt_q, cnt_d, carry_q;

    logic [3*CD-1:0] s1_rgb_q, s2_rgb_q;
    logic            s1_dv_q, s1_hs_q, s1_vs_q, s2_dv_q, s2_hs_q, s2_vs_q;
    logic [1:0]      s1_mode_q, s2_mode_q;
    logic signed [W-1:0] comp [3];
    logic signed [W-1:0] prod_d [9];
    logic signed [W-1:0] s2_prod_q [9];

    logic signed [W-1:0] sum_y, sum_cb, sum_cr;
    logic [3*CD-1:0]     ycc_d, ycc_q;
    logic                dv_q, hs_q, vs_q, le_q;
    logic [CNTW-1:0]     len_q;

    // Reserved mode 3 is treated as YCbCr.
    assign mode_eff = (mode_q == 2'd3) ? 2'd1 : mode_q;
    assign cnt_d    = !dv_i ? '0 : (cnt_q == CNTW'(MAXW)) ? cnt_q : cnt_q + 1'b1;

    // Stage 1: inputs, mode latch, and line counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb_q  <= '0;
            s1_dv_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_mode_q <= 2'd1;
            mode_q    <= 2'd1;
            vs_prev_q <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= '0;
        end else begin
            s1_rgb_q  <= rgb_i;
            s1_dv_q   <= dv_i;
            s1_hs_q   <= hs_i;
            s1_vs_q   <= vs_i;
            s1_mode_q <= mode_eff;
            vs_prev_q <= vs_i;
            if (vs_i && !vs_prev_q) mode_q <= mode_i;
            cnt_q <= cnt_d;
            // s1_dv_q is the previous dv_i, so this detects the input-side falling edge.
            if (!dv_i && s1_dv_q) carry_q <= cnt_q;
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) comp[c] = signed'(W'(s1_rgb_q[(2-c)*CD +: CD]));
        for (int i = 0; i < 9; i++) prod_d[i] = signed'(W'(COEF[i])) * comp[i % 3];
    end

    // Stage 2: the nine products.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) s2_prod_q[i] <= '0;
            s2_rgb_q  <= '0;
            s2_dv_q   <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            s2_mode_q <= 2'd1;
        end else begin
            for (int i = 0; i < 9; i++) s2_prod_q[i] <= prod_d[i];
            s2_rgb_q  <= s1_rgb_q;
            s2_dv_q   <= s1_dv_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            s2_mode_q <= s1_mode_q;
        end
    end

    function automatic logic [CD-1:0] clamp(input logic signed [W-1:0] v);
        if (v < 0)         return '0;
        else if (v > VMAX) return CD'(MAXV);
        else               return v[CD-1:0];
    endfunction

    always_comb begin
        sum_y  = (s2_prod_q[0] + s2_prod_q[1] + s2_prod_q[2] + RND) >>> 8;
        sum_cb = ((s2_prod_q[3] + s2_prod_q[4] + s2_prod_q[5] + RND) >>> 8) + OFF;
        sum_cr = ((s2_prod_q[6] + s2_prod_q[7] + s2_prod_q[8] + RND) >>> 8) + OFF;
        ycc_d  = '0;
        if (s2_dv_q) begin
            case (s2_mode_q)
                2'd0:    ycc_d = {clamp(sum_y), HALF, HALF};
                2'd2:    ycc_d = s2_rgb_q;
                default: ycc_d = {clamp(sum_y), clamp(sum_cb), clamp(sum_cr)};
            endcase
        end
    end

    // Stage 3: outputs. A line ends where stage 2 is valid and stage 1 is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            ycc_q <= '0;
            dv_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            le_q  <= 1'b0;
            len_q <= '0;
        end else begin
            ycc_q <= ycc_d;
            dv_q  <= s2_dv_q;
            hs_q  <= s2_hs_q;
            vs_q  <= s2_vs_q;
            le_q  <= s2_dv_q && !s1_dv_q;
            if (s2_dv_q && !s1_dv_q) len_q <= carry_q;
        end
    end

    assign ycc_o      = ycc_q;
    assign dv_o       = dv_q;
    assign hs_o       = hs_q;
    assign vs_o       = vs_q;
    assign line_end_o = le_q;
    assign line_len_o = len_q;
    assign mode_o     = mode_eff;
endmodule

// File: tb/tb_rgb2ycc.sv
// Scoreboard bench for rgb2ycc. Stimulus pushes model results into queues,
// and a monitor pops and compares them against the DUT outputs.
module tb_rgb2ycc;
    localparam int CD   = 8;
    localparam int MAXW = 2048;
    localparam int CNTW = $clog2(MAXW + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3*CD-1:0] rgb_i = '0;
    logic            dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [1:0]      mode_i = 2'd1;
    logic [3*CD-1:0] ycc_o;
    logic            dv_o, hs_o, vs_o, line_end_o;
    logic [CNTW-1:0] line_len_o;
    logic [1:0]      mode_o;

    rgb2ycc #(.COLORDEPTH(CD), .MAXW(MAXW)) dut (
        .clk(clk), .rst(rst), .rgb_i(rgb_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .mode_i(mode_i), .ycc_o(ycc_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .line_end_o(line_end_o), .line_len_o(line_len_o), .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            hs;
        logic            vs;
        logic [3*CD-1:0] ycc;
    } exp_t;

    exp_t pq[$];
    int   lq[$];
    int   checks = 0, failures = 0;
    int   mode_m = 1, cnt_m = 0;
    bit   prev_dv_m = 0, prev_vs_m = 0;

    function automatic int clampf(input int v);
        if (v < 0) return 0;
        if (v > (1 << CD) - 1) return (1 << CD) - 1;
        return v;
    endfunction

    function automatic logic [3*CD-1:0] ref_ycc(input logic [3*CD-1:0] px, input int md);
        int r, g, b, y, cb, cr, half;
        r = int'(px[2*CD +: CD]);
        g = int'(px[CD +: CD]);
        b = int'(px[0 +: CD]);
        half = 1 << (CD - 1);
        if (md == 2) return px;
        y  = clampf((77 * r + 150 * g + 29 * b + 128) >>> 8);
        cb = clampf(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + half);
        cr = clampf(((128 * r - 107 * g - 21 * b + 128) >>> 8) + half);
        if (md == 0) begin
            cb = half;
            cr = half;
        end
        return {CD'(y), CD'(cb), CD'(cr)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit dv, input bit hs, input bit vs, input logic [1:0] md,
                         input logic [3*CD-1:0] px);
        @(posedge clk);
        #1;
        rst = 1'b0; dv_i = dv; hs_i = hs; vs_i = vs; mode_i = md; rgb_i = px;
        if (dv) begin
            pq.push_back('{hs: hs, vs: vs, ycc: ref_ycc(px, mode_m)});
            cnt_m = (cnt_m < MAXW) ? cnt_m + 1 : MAXW;
        end else begin
            if (prev_dv_m) lq.push_back(cnt_m);
            cnt_m = 0;
        end
        prev_dv_m = dv;
        // A rising edge on vs takes effect from the next pixel onward.
        if (vs && !prev_vs_m) mode_m = (md == 2'd3) ? 1 : int'(md);
        prev_vs_m = vs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'd0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; dv_i = 0; hs_i = 0; vs_i = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pq.delete();
        lq.delete();
        mode_m = 1; cnt_m = 0; prev_dv_m = 0; prev_vs_m = 0;
        check("rst_ycc", ycc_o, 0);
        check("rst_dv", {hs_o, vs_o, dv_o, line_end_o}, 0);
        check("rst_len", line_len_o, 0);
        check("rst_mode", mode_o, 1);
    endtask

    initial begin : monitor
        bit   ra, mprev, mle;
        exp_t e;
        mprev = 0;
        mle   = 0;
        forever begin
            @(posedge clk) ra = rst;
            @(negedge clk);
            if (ra) begin
                mprev = 0;
                mle   = 0;
            end else begin
                if (dv_o) begin
                    if (pq.size() == 0) begin
                        check("unexpected_pixel", 1, 0);
                    end else begin
                        e = pq.pop_front();
                        check("ycc", ycc_o, e.ycc);
                        check("hs", hs_o, e.hs);
                        check("vs", vs_o, e.vs);
                    end
                    mle = line_end_o;
                    if (line_end_o) begin
                        if (lq.size() == 0) check("unexpected_line_end", 1, 0);
                        else check("line_len", line_len_o, lq.pop_front());
                    end
                end else begin
                    check("ycc_idle_zero", ycc_o, 0);
                    check("line_end_no_dv", line_end_o, 0);
                    if (mprev) check("line_end_at_last", mle, 1);
                end
                mprev = dv_o;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    localparam logic [3*CD-1:0] WHITE = 24'hFFFFFF;
    localparam logic [3*CD-1:0] BLACK = 24'h000000;
    localparam logic [3*CD-1:0] RED   = 24'hFF0000;
    localparam logic [3*CD-1:0] BLUE  = 24'h0000FF;

    initial begin : stim
        repeat (3) @(posedge clk);
        do_reset();

        // Default mode is YCbCr.
        drive(1, 0, 0, 2'd1, WHITE);
        drive(1, 0, 0, 2'd1, BLACK);
        idle(1);
        drive(1, 1, 0, 2'd1, RED);
        idle(1);
        drive(1, 0, 0, 2'd1, BLUE);
        idle(3);

        // The mode is latched only on a rising edge of vs.
        drive(0, 0, 1, 2'd0, '0);
        drive(0, 0, 1, 2'd0, '0);
        check("mode_y_only", mode_o, 0);
        drive(1, 0, 1, 2'd2, RED);
        drive(0, 0, 0, 2'd2, '0);
        drive(1, 0, 0, 2'd2, RED);
        check("mode_ignored", mode_o, 0);
        drive(0, 0, 1, 2'd2, '0);
        drive(1, 0, 1, 2'd2, RED);
        check("mode_bypass", mode_o, 2);
        drive(0, 0, 0, 2'd0, '0);
        // A vs rising edge together with a pixel: the same-cycle pixel still uses the old mode.
        drive(1, 0, 1, 2'd0, RED);
        drive(1, 0, 1, 2'd0, RED);
        drive(0, 0, 0, 2'd3, '0);
        drive(0, 0, 1, 2'd3, '0);
        drive(1, 0, 0, 2'd3, BLUE);
        check("mode_reserved", mode_o, 1);
        idle(4);

        // A 640-pixel line, a 4-cycle gap, then a 1-pixel line.
        for (int i = 0; i < 640; i++) drive(1, i < 16, 0, 2'd1, 24'($urandom));
        idle(4);
        drive(1, 0, 0, 2'd1, 24'($urandom));
        idle(4);

        // This line length saturates at MAXW.
        for (int i = 0; i < 2100; i++) drive(1, 0, 0, 2'd1, 24'($urandom));
        idle(4);

        // Random lines with single- and multi-cycle gaps, random syncs and modes.
        for (int k = 0; k < 150; k++) begin
            int len, gap;
            len = $urandom_range(1, 24);
            gap = $urandom_range(1, 3);
            for (int j = 0; j < len; j++)
                drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                      2'($urandom_range(0, 3)), 24'($urandom));
            for (int j = 0; j < gap; j++)
                drive(0, 0, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), '0);
        end
        idle(4);

        // Reset in the middle of a line, then resume.
        drive(0, 0, 1, 2'd0, '0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 2'd0, 24'($urandom));
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 2'd0, 24'($urandom));
        idle(6);

        check("pixel_queue_drained", pq.size(), 0);
        check("len_queue_drained", lq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
